// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for mem_access_unit: access size codes, FSM state
// encodings, data-memory depth and the misalignment predicate.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_STORE  = 3'd2;
  localparam logic [2:0] ST_RMW_RD = 3'd3;
  localparam logic [2:0] ST_RMW_WR = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  localparam int unsigned DMEM_SIZE = 1024;

  // Reserved size 11 is a word access, so it shares the word alignment rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    unique case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = |lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// lane_align: little-endian lane extract with sign/zero extension (merge=0)
// or lane merge of data into word (merge=1). Purely combinational.
module lane_align
  import mem_access_unit_pkg::*;
(
  input  logic        merge,
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_v;
  logic [31:0] merged_v;

  always_comb begin
    unique case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = lane[1] ? word[31:16] : word[15:0];

    unique case (size)
      SZ_BYTE: ext_v = {{24{sign_ext & byte_v[7]}}, byte_v};
      SZ_HALF: ext_v = {{16{sign_ext & half_v[15]}}, half_v};
      default: ext_v = word;
    endcase

    // lane[0] is ignored for halves, so unaligned halves land on addr[1]
    merged_v = word;
    unique case (size)
      SZ_BYTE: begin
        unique case (lane)
          2'd0:    merged_v[7:0]   = data[7:0];
          2'd1:    merged_v[15:8]  = data[7:0];
          2'd2:    merged_v[23:16] = data[7:0];
          default: merged_v[31:24] = data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merged_v[31:16] = data[15:0];
        else         merged_v[15:0]  = data[15:0];
      end
      default: merged_v = data;
    endcase

    result = merge ? merged_v : ext_v;
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of a word-wide d_mem, with
// read-modify-write for sub-word stores. Optional misaligned-access trap
// enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [2:0]        state_q,  state_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [1:0]        size_q,   size_d;
  logic              sext_q,   sext_d;
  logic [31:0]       wdata_q,  wdata_d;
  logic [31:0]       merged_q, merged_d;
  logic [31:0]       rdata_q,  rdata_d;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic              mis_q,    mis_d;
`endif

  logic [31:0] load_lane;
  logic [31:0] merge_lane;
  logic        mem_cycle;

  lane_align u_load_align (
    .merge    (1'b0),
    .word     (mem_rdata),
    .data     (wdata_q),
    .lane     (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sext_q),
    .result   (load_lane)
  );

  lane_align u_merge_align (
    .merge    (1'b1),
    .word     (mem_rdata),
    .data     (wdata_q),
    .lane     (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sext_q),
    .result   (merge_lane)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    sext_d   = sext_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    mis_d    = mis_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (req) begin
          addr_d  = addr;
          size_d  = size;
          sext_d  = sign_ext;
          wdata_d = wdata;
          if (!we)          state_d = ST_LOAD;
          else if (size[1]) state_d = ST_STORE;
          else              state_d = ST_RMW_RD;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          mis_d = is_misaligned(size, addr[1:0]);
          if (mis_d) state_d = ST_RESP;
`endif
        end
      end
      ST_LOAD: begin
        rdata_d = load_lane;
        state_d = ST_RESP;
      end
      ST_STORE:  state_d = ST_RESP;
      ST_RMW_RD: begin
        merged_d = merge_lane;
        state_d  = ST_RMW_WR;
      end
      ST_RMW_WR: state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    addr_q   <= addr_d;
    size_q   <= size_d;
    sext_q   <= sext_d;
    wdata_q  <= wdata_d;
    merged_q <= merged_d;
  end

  // Strobes are gated by reset so an interrupted store/RMW never writes.
  always_comb begin
    mem_cycle = (state_q == ST_LOAD)   || (state_q == ST_STORE) ||
                (state_q == ST_RMW_RD) || (state_q == ST_RMW_WR);
    busy      = (state_q != ST_IDLE) && (state_q != ST_RESP);
    done      = (state_q == ST_RESP);
    mem_read  = !reset && ((state_q == ST_LOAD)  || (state_q == ST_RMW_RD));
    mem_write = !reset && ((state_q == ST_STORE) || (state_q == ST_RMW_WR));
    mem_addr  = mem_cycle ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    unique case (state_q)
      ST_STORE:  mem_wdata = wdata_q;
      ST_RMW_WR: mem_wdata = merged_q;
      default:   mem_wdata = '0;
    endcase
  end

  assign rdata = rdata_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign misalign = done & mis_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural word-wide d_mem.
// Honours MEM_ACCESS_MISALIGN_TRAP_EN when it is defined for the build.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic        misalign;
`endif
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clock = ~clock;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    .misalign  (misalign),
`endif
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] dmem    [0:63];
  logic [31:0] ref_mem [0:63];

  assign mem_rdata = mem_read ? dmem[mem_addr[7:2]] : 32'h0;
  always @(posedge clock) if (mem_write) dmem[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    string       tag;
    int unsigned lat;
    int unsigned rd;
    int unsigned wr;
    logic [31:0] rdata;
    logic        mis;
    int unsigned acc_cyc;
  } exp_t;

  exp_t        sb_q [$];
  exp_t        mon_e;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;
  logic [31:0] last_rdata = 32'h0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] sz,
                                         input logic sx, input logic [1:0] lo);
    logic [31:0] sh;
    if (sz == 2'b00) begin
      sh = w >> {lo, 3'b000};
      return sx ? 32'($signed(sh[7:0])) : {24'h0, sh[7:0]};
    end else if (sz == 2'b01) begin
      sh = w >> {lo[1], 4'b0000};
      return sx ? 32'($signed(sh[15:0])) : {16'h0, sh[15:0]};
    end
    return w;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] mask;
    logic [4:0]  sh;
    if (sz[1]) return d;
    sh   = (sz == 2'b00) ? {lo, 3'b000} : {lo[1], 4'b0000};
    mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // Protocol checks every cycle plus scoreboard pop on each done pulse.
  always @(negedge clock) begin
    if (reset) begin
      sb_q.delete();
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      check("rw_excl", 32'(mem_read & mem_write), 32'h0);
      if (!busy) check("idle_bus", {28'h0, mem_read, mem_write, |mem_addr, |mem_wdata}, 32'h0);
      else       check("addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (done) begin
        if (sb_q.size() == 0) check("spurious_done", 32'h1, 32'h0);
        else begin
          mon_e = sb_q.pop_front();
          check({mon_e.tag, "_lat"},   cyc - mon_e.acc_cyc + 1, mon_e.lat);
          check({mon_e.tag, "_rd"},    rd_cnt, mon_e.rd);
          check({mon_e.tag, "_wr"},    wr_cnt, mon_e.wr);
          check({mon_e.tag, "_rdata"}, rdata, mon_e.rdata);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          check({mon_e.tag, "_mis"},   32'(misalign), 32'(mon_e.mis));
`endif
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  // Called and returns at a negedge; pushes the expectation right after acceptance.
  task automatic issue(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold,
                       output int unsigned acc);
    exp_t        e;
    int unsigned idx;
    int unsigned guard;
    idx   = 32'(a[7:2]);
    guard = 0;
    acc   = 0;
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    while (busy && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (busy) begin
      check({tag, "_accept_timeout"}, 32'h1, 32'h0);
      req = 1'b0;
      return;
    end
    e.tag = tag;
    e.mis = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    e.mis = (sz == 2'b01) ? a[0] : (sz[1] ? (a[1:0] != 2'b00) : 1'b0);
`endif
    if (e.mis) begin
      e.lat = 1; e.rd = 0; e.wr = 0;
    end else if (!w) begin
      e.lat = 2; e.rd = 1; e.wr = 0;
      last_rdata = f_load(ref_mem[idx], sz, sx, a[1:0]);
    end else if (sz[1]) begin
      e.lat = 2; e.rd = 0; e.wr = 1;
      ref_mem[idx] = wd;
    end else begin
      e.lat = 3; e.rd = 1; e.wr = 1;
      ref_mem[idx] = f_merge(ref_mem[idx], wd, sz, a[1:0]);
    end
    e.rdata = last_rdata;
    @(posedge clock);
    #1;
    e.acc_cyc = cyc;
    acc       = cyc;
    sb_q.push_back(e);
    @(negedge clock);
    if (!hold) req = 1'b0;
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 30) begin
      @(negedge clock);
      guard++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int unsigned acc1, acc2, nbad;
    logic [31:0] saved;
    for (int i = 0; i < 64; i++) begin
      dmem[i]    = 32'(i) * 32'h0101_0101 ^ 32'hA500_0000;
      ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA500_0000;
    end
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clock);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_strobe", {30'h0, mem_read, mem_write}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    issue("st_word",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, acc1);
    issue("ld_word",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, acc1);
    issue("ld_sbyte", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, acc1);
    drain();
    check("sbyte_value", rdata, 32'hFFFF_FFDE);
    issue("ld_ubyte", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, acc1);
    drain();
    check("ubyte_value", rdata, 32'h0000_00DE);
    issue("st_byte",  1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0055, 1'b0, acc1);
    issue("ld_merged", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, acc1);
    drain();
    check("rmw_value", rdata, 32'hDEAD_55EF);
    issue("st_half",  1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_A5A5, 1'b0, acc1);
    issue("ld_shalf", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, acc1);
    issue("ld_uhalf", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, acc1);
    issue("st_rsvd",  1'b1, 2'b11, 1'b0, 32'h20, 32'h1234_8765, 1'b0, acc1);
    issue("ld_mis_half", 1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 1'b0, acc1);
    issue("ld_mis_word", 1'b0, 2'b10, 1'b0, 32'h16, 32'h0, 1'b0, acc1);

    issue("b2b_1", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, acc1);
    issue("b2b_2", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0, acc2);
    check("b2b_gap", acc2 - acc1, 32'd2);
    drain();

    issue("ld_busy", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, acc1);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'hBAD0_BAD0;
    @(negedge clock);
    req = 1'b0;
    drain();
    issue("ld_after_busy", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, acc1);
    drain();

    saved = ref_mem[4];
    issue("st_rst", 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0077, 1'b0, acc1);
    ref_mem[4] = saved;
    begin
      int unsigned guard;
      guard = 0;
      while (!mem_write && guard < 5) begin
        @(negedge clock);
        guard++;
      end
      check("rst_reach_rmw_wr", 32'(mem_write), 32'h1);
    end
    reset = 1'b1;
    #1;
    check("rst_mid_wr_gate", 32'(mem_write), 32'h0);
    @(posedge clock);
    #1;
    check("rst_mid_busy",  32'(busy), 32'h0);
    check("rst_mid_done",  32'(done), 32'h0);
    check("rst_mid_rdata", rdata, 32'h0);
    check("rst_mid_mem",   dmem[4], saved);
    last_rdata = 32'h0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    issue("ld_after_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, acc1);

    for (int i = 0; i < 24; i++) begin
      issue("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom, 1'b0, acc1);
    end
    drain();

    nbad = 0;
    for (int i = 0; i < 64; i++) if (dmem[i] !== ref_mem[i]) nbad++;
    check("mem_final", nbad, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
